// File: rtl/gatherer.sv
// gatherer: serial-to-parallel collector of LEN words of N bits.
// Presents the assembled vector on a valid/ready handshake.
module gatherer #(
  parameter int N   = 16,
  parameter int LEN = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        in_valid,
  input  logic [N-1:0]                in,
  output logic                        in_ready,
  output logic [LEN-1:0][N-1:0]       out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(LEN+1)-1:0]    count
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int CW = $clog2(LEN + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LEN-1:0][N-1:0] out_q, out_d;

  logic accept;
  logic rel;

  assign in_ready  = ena && ((state_q == FILL) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign rel       = out_valid && out_ready && ena;

  assign out   = out_q;
  assign count = count_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    out_d   = out_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          out_d[idx_q] = in;
          count_d      = count_q + CW'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      HOLD: begin
        // accept in HOLD implies release: the new word starts the next vector
        if (rel && accept) begin
          out_d[0] = in;
          count_d  = CW'(1);
          if (LEN == 1) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d   = IDX_ONE;
            state_d = FILL;
          end
        end else if (rel) begin
          idx_d   = '0;
          count_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_gatherer.sv
// tb_gatherer: table vectors, corner sequences and random stimulus
// checked against a queue-style reference model.
module tb_gatherer;

  localparam int N   = 16;
  localparam int LEN = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             in_valid;
  logic [N-1:0]     din;
  logic             in_ready;
  logic [LEN-1:0][N-1:0] dout;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       count;

  logic             ena1;
  logic             iv1;
  logic [N-1:0]     din1;
  logic             rdy1;
  logic [0:0][N-1:0] dout1;
  logic             vld1;
  logic             ordy1;
  logic [0:0]       count1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gatherer #(.N(N), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in(din), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  gatherer #(.N(N), .LEN(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena1),
    .in_valid(iv1), .in(din1), .in_ready(rdy1),
    .out(dout1), .out_valid(vld1), .out_ready(ordy1),
    .count(count1)
  );

  // reference model: words collected so far plus the presented vector
  logic [N-1:0] m_vec [LEN];
  bit           m_valid;
  int           m_fill;

  function automatic bit m_ready(bit e, bit o);
    return e && (!m_valid || o);
  endfunction

  function automatic int m_count();
    return m_valid ? LEN : m_fill;
  endfunction

  function automatic logic [47:0] m_out();
    logic [47:0] v = '0;
    for (int k = 0; k < LEN; k++) v[k*N +: N] = m_vec[k];
    return v;
  endfunction

  task automatic m_step(bit r, bit e, bit v, logic [N-1:0] d, bit o);
    bit acc;
    if (r) begin
      m_valid = 0;
      m_fill  = 0;
      for (int k = 0; k < LEN; k++) m_vec[k] = '0;
    end else if (e) begin
      acc = v && m_ready(e, o);
      if (m_valid && o) begin
        m_valid = 0;
        m_fill  = 0;
      end
      if (acc) begin
        m_vec[m_fill] = d;
        m_fill++;
        if (m_fill == LEN) begin
          m_valid = 1;
          m_fill  = 0;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic cyc(bit r, bit e, bit v, logic [N-1:0] d, bit o);
    rst       = r;
    ena       = e;
    in_valid  = v;
    din       = d;
    out_ready = o;
    #1;
    chk("in_ready", 64'(in_ready), 64'(m_ready(e, o)));
    @(posedge clk);
    m_step(r, e, v, d, o);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("count", 64'(count), 64'(m_count()));
    chk("out", 64'(dout), 64'(m_out()));
  endtask

  typedef struct {
    bit          r, e, v, o;
    logic [15:0] d;
    bit          erdy, evld;
    int          ecnt;
    logic [47:0] eout;
  } vec_t;

  vec_t tbl [11];
  int   vld_cycles;

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 16'h0000, 1, 0, 0, 48'h0000_0000_0000};
    tbl[1]  = '{0, 1, 1, 0, 16'hAAAA, 1, 0, 1, 48'h0000_0000_AAAA};
    tbl[2]  = '{0, 1, 1, 0, 16'hBBBB, 1, 0, 2, 48'h0000_BBBB_AAAA};
    tbl[3]  = '{0, 1, 1, 0, 16'hCCCC, 1, 1, 3, 48'hCCCC_BBBB_AAAA};
    for (int i = 4; i < 9; i++)
      tbl[i] = '{0, 1, 1, 0, 16'hDDDD, 0, 1, 3, 48'hCCCC_BBBB_AAAA};
    tbl[9]  = '{0, 1, 0, 1, 16'h0000, 1, 0, 0, 48'hCCCC_BBBB_AAAA};
    tbl[10] = '{0, 1, 1, 0, 16'hEEEE, 1, 0, 1, 48'hCCCC_BBBB_EEEE};

    ena1 = 0; iv1 = 0; din1 = '0; ordy1 = 0;
    rst = 1; ena = 1; in_valid = 0; din = '0; out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    m_step(1, 1, 0, '0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, '0, 0);
    chk("reset_out", 64'(dout), 64'h0);
    chk("reset_count", 64'(count), 64'h0);
    chk("reset_valid", 64'(out_valid), 64'h0);

    // basic fill, hold and release
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].r; ena = tbl[i].e; in_valid = tbl[i].v;
      din = tbl[i].d; out_ready = tbl[i].o;
      #1;
      chk($sformatf("tbl%0d_rdy", i), 64'(in_ready), 64'(tbl[i].erdy));
      @(posedge clk);
      m_step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].o);
      @(negedge clk);
      chk($sformatf("tbl%0d_vld", i), 64'(out_valid), 64'(tbl[i].evld));
      chk($sformatf("tbl%0d_cnt", i), 64'(count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_out", i), 64'(dout), 64'(tbl[i].eout));
    end

    // back-to-back streaming
    cyc(1, 1, 0, '0, 1);
    vld_cycles = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 1, 16'(i), 1);
      chk("b2b_rdy", 64'(in_ready), 64'h1);
      if (out_valid) vld_cycles++;
      if (i == 3) chk("b2b_vec0", 64'(dout), 64'h0003_0002_0001);
      if (i == 4) chk("b2b_gap", 64'(out_valid), 64'h0);
      if (i == 6) chk("b2b_vec1", 64'(dout), 64'h0006_0005_0004);
    end
    chk("b2b_pulses", 64'(vld_cycles), 64'd2);

    // gaps and ena low
    cyc(1, 1, 0, '0, 1);
    cyc(0, 1, 1, 16'h1111, 1);
    cyc(0, 1, 0, 16'h0000, 1);
    cyc(0, 1, 0, 16'h0000, 1);
    cyc(0, 1, 1, 16'h2222, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 16'hFFFF, 1);
      chk("ena_low_cnt", 64'(count), 64'd2);
      chk("ena_low_rdy", 64'(in_ready), 64'h0);
    end
    cyc(0, 1, 1, 16'h3333, 0);
    chk("gap_vec", 64'(dout), 64'h3333_2222_1111);
    chk("gap_vld", 64'(out_valid), 64'h1);
    cyc(0, 0, 0, 16'h0000, 1);
    chk("ena_low_hold", 64'(out_valid), 64'h1);

    // reset mid-vector
    cyc(1, 1, 0, '0, 1);
    cyc(0, 1, 1, 16'h1234, 1);
    cyc(0, 1, 1, 16'h5678, 1);
    chk("mid_cnt", 64'(count), 64'd2);
    cyc(1, 1, 0, '0, 1);
    chk("mid_rst_out", 64'(dout), 64'h0);
    chk("mid_rst_cnt", 64'(count), 64'h0);
    cyc(0, 1, 1, 16'h9ABC, 0);
    cyc(0, 1, 1, 16'hDEF0, 0);
    cyc(0, 1, 1, 16'h0F0F, 0);
    chk("mid_vec", 64'(dout), 64'h0F0F_DEF0_9ABC);

    // LEN=1 instance streaming
    ena1 = 1; ordy1 = 1; iv1 = 1; din1 = 16'h00AA;
    #1;
    chk("len1_rdy0", 64'(rdy1), 64'h1);
    @(negedge clk);
    chk("len1_vld0", 64'(vld1), 64'h1);
    chk("len1_out0", 64'(dout1), 64'h00AA);
    chk("len1_cnt0", 64'(count1), 64'h1);
    din1 = 16'h00BB;
    #1;
    chk("len1_rdy1", 64'(rdy1), 64'h1);
    @(negedge clk);
    chk("len1_vld1", 64'(vld1), 64'h1);
    chk("len1_out1", 64'(dout1), 64'h00BB);
    chk("len1_cnt1", 64'(count1), 64'h1);
    iv1 = 0;
    @(negedge clk);
    chk("len1_drain", 64'(vld1), 64'h0);
    ena1 = 0;

    // randomized stimulus against the model
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(63) == 0), ($urandom_range(7) != 0),
          ($urandom_range(3) != 0), 16'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
